// File: rtl/tetris_pkg.sv
// Shared constants for the drop-tick scheduler: FSM encodings, default
// periods and the level-to-period mapping.
package tetris_pkg;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_RUN   = 2'b01;
   localparam logic [1:0] ST_PAUSE = 2'b10;

   localparam int          DEF_PIX_DIV     = 4;
   localparam logic [19:0] DEF_BASE_PERIOD = 20'd750000;
   localparam logic [19:0] DEF_STEP        = 20'd50000;
   localparam logic [19:0] DEF_MIN_PERIOD  = 20'd50000;
   localparam logic [19:0] DEF_SOFT_PERIOD = 20'd25000;

   // max(min_p, base - lvl*step) in 24 bits; a would-be negative result
   // clamps to min_p instead of wrapping.
   function automatic logic [23:0] level_period(input logic [3:0]  lvl,
                                                input logic [19:0] base,
                                                input logic [19:0] step,
                                                input logic [19:0] min_p);
      logic [23:0] v_dec;
      logic [23:0] v_base;
      logic [23:0] v_min;
      logic [23:0] v_res;
      v_dec  = {20'd0, lvl} * {4'd0, step};
      v_base = {4'd0, base};
      v_min  = {4'd0, min_p};
      if (v_dec >= v_base) v_res = v_min;
      else                 v_res = v_base - v_dec;
      if (v_res < v_min)   v_res = v_min;
      return v_res;
   endfunction

endpackage

// File: rtl/pix_en_gen.sv
// Pixel-enable generator: registered one-cycle pulse every PIX_DIV clocks,
// high exactly while the divider count sits at PIX_DIV-1.
module pix_en_gen #(
   parameter int PIX_DIV = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   output logic o_pix_en
);

   localparam int CW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(PIX_DIV - 1);

   logic [CW-1:0] r_pix_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          r_pix_en;

   assign w_cnt_nxt = (r_pix_cnt == LAST) ? '0 : r_pix_cnt + 1'b1;
   assign o_pix_en  = r_pix_en;

   // Divider counter; the pulse is registered from the next count so it
   // lines up with pix_cnt == PIX_DIV-1.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pix_cnt <= '0;
         r_pix_en  <= 1'b0;
      end else begin
         r_pix_cnt <= w_cnt_nxt;
         r_pix_en  <= (w_cnt_nxt == LAST);
      end
   end

endmodule

// File: rtl/tick_sched_module.sv
// Drop-tick scheduler: IDLE/RUN/PAUSE FSM plus a pix_en-paced drop counter
// whose period follows the latched level or the soft-drop override.
module tick_sched_module
   import tetris_pkg::*;
#(
   parameter int          PIX_DIV     = DEF_PIX_DIV,
   parameter logic [19:0] BASE_PERIOD = DEF_BASE_PERIOD,
   parameter logic [19:0] STEP        = DEF_STEP,
   parameter logic [19:0] MIN_PERIOD  = DEF_MIN_PERIOD,
   parameter logic [19:0] SOFT_PERIOD = DEF_SOFT_PERIOD
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       start,
   input  logic       pause_req,
   input  logic       resume_req,
   input  logic [3:0] level,
   input  logic       level_load,
   input  logic       soft_drop,
   output logic       pix_en,
   output logic       drop_tick,
   output logic [1:0] state
);

   logic        w_pix_en;
   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;
   logic [3:0]  r_level;
   logic [19:0] r_drop_cnt;
   logic        r_drop_tick;
   logic [23:0] w_cur_period;
   logic        w_at_end;

   pix_en_gen #(.PIX_DIV(PIX_DIV)) u_pix_en_gen (
      .i_clk    (clk_in),
      .i_rst    (rst_in),
      .o_pix_en (w_pix_en)
   );

   assign pix_en    = w_pix_en;
   assign drop_tick = r_drop_tick;
   assign state     = r_state;

   // Period is re-evaluated every cycle, so level/soft-drop changes apply
   // on the very next pix_en without touching the counter.
   always_comb begin
      w_cur_period = level_period(r_level, BASE_PERIOD, STEP, MIN_PERIOD);
      if (soft_drop) w_cur_period = {4'd0, SOFT_PERIOD};
   end

   // ">= period-1" written as "+1 >= period" to avoid underflow; this also
   // fires immediately when a shorter period leaves the count overshot.
   assign w_at_end = (({4'd0, r_drop_cnt} + 24'd1) >= w_cur_period);

   // Next-state logic; pause wins when pause and resume arrive together.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (start)                    w_state_nxt = ST_RUN;
         ST_RUN:   if (pause_req)                w_state_nxt = ST_PAUSE;
         ST_PAUSE: if (resume_req && !pause_req) w_state_nxt = ST_RUN;
         default:                                w_state_nxt = ST_IDLE;
      endcase
   end

   // State and level registers.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state <= ST_IDLE;
         r_level <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         if (level_load) r_level <= level;
      end
   end

   // Drop counter: counts pix_en only in RUN, frozen in PAUSE, zero in IDLE
   // (so entering RUN from IDLE always starts from 0). The tick is set by
   // the current state, so a tick earned on the pause edge still appears.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_drop_cnt  <= 20'd0;
         r_drop_tick <= 1'b0;
      end else begin
         r_drop_tick <= 1'b0;
         case (r_state)
            ST_RUN: begin
               if (w_pix_en) begin
                  if (w_at_end) begin
                     r_drop_cnt  <= 20'd0;
                     r_drop_tick <= 1'b1;
                  end else begin
                     r_drop_cnt  <= r_drop_cnt + 20'd1;
                  end
               end
            end
            ST_PAUSE: r_drop_cnt <= r_drop_cnt;
            default:  r_drop_cnt <= 20'd0;
         endcase
      end
   end

endmodule

// File: tb/tb_tick_sched_module.sv
// Scoreboard bench for tick_sched_module: expected tick cycles are queued
// when stimulus is applied and matched against each observed drop_tick.
module tb_tick_sched_module;

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b1;
   logic       start = 1'b0;
   logic       pause_req = 1'b0;
   logic       resume_req = 1'b0;
   logic [3:0] level = 4'd0;
   logic       level_load = 1'b0;
   logic       soft_drop = 1'b0;
   logic       pix_en;
   logic       drop_tick;
   logic [1:0] state;

   tick_sched_module #(
      .PIX_DIV     (4),
      .BASE_PERIOD (20'd20),
      .STEP        (20'd2),
      .MIN_PERIOD  (20'd4),
      .SOFT_PERIOD (20'd2)
   ) dut (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .start      (start),
      .pause_req  (pause_req),
      .resume_req (resume_req),
      .level      (level),
      .level_load (level_load),
      .soft_drop  (soft_drop),
      .pix_en     (pix_en),
      .drop_tick  (drop_tick),
      .state      (state)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;
   int t0     = 0;
   int q[$];
   int mon_exp;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cyc %0d)", tag, act, exp, cyc);
   endtask

   // Every tick must match the oldest queued expectation.
   always @(negedge clk_in) begin
      if (drop_tick === 1'b1) begin
         if (q.size() == 0) chk("unexpected_tick", cyc, -1);
         else begin
            mon_exp = q.pop_front();
            chk("tick_cycle", cyc, mon_exp);
         end
      end
   end

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk_in);
   endtask

   // Reset, release, and stop on the first pix_en cycle (phase 3 from release).
   task automatic restart(output int c0);
      rst_in = 1'b1; start = 1'b0; pause_req = 1'b0; resume_req = 1'b0;
      level_load = 1'b0; soft_drop = 1'b0;
      repeat (2) @(negedge clk_in);
      rst_in = 1'b0;
      t0 = cyc;
      @(negedge clk_in);
      while (((cyc - t0) % 4) != 3) @(negedge clk_in);
      c0 = cyc;
   endtask

   task automatic go(input logic [3:0] lv);
      level = lv; level_load = 1'b1; start = 1'b1;
      @(negedge clk_in);
      level_load = 1'b0; start = 1'b0;
   endtask

   int c0;
   int lv_tab[5]  = '{3, 8, 9, 10, 15};
   int per_tab[5] = '{14, 4, 4, 4, 4};

   initial begin
      // reset values and free-running pix_en while idle
      repeat (3) @(negedge clk_in);
      chk("rst_pix_en", int'(pix_en), 0);
      chk("rst_drop_tick", int'(drop_tick), 0);
      chk("rst_state", int'(state), 0);
      rst_in = 1'b0;
      t0 = cyc;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk_in);
         chk("pix_en", int'(pix_en), (((cyc - t0) % 4) == 3) ? 1 : 0);
      end
      chk("idle_state", int'(state), 0);

      // level 0: first tick after the 20th RUN pix_en, then every 80 clocks
      restart(c0);
      go(4'd0);
      q.push_back(c0 + 81);
      q.push_back(c0 + 161);
      chk("run_state", int'(state), 1);
      wait_cyc(c0 + 170);
      chk("q_empty_l0", q.size(), 0);

      // level-derived periods, including exact-min and negative clamps
      for (int i = 0; i < 5; i++) begin
         restart(c0);
         go(4'(lv_tab[i]));
         q.push_back(c0 + 1 + per_tab[i] * 4);
         q.push_back(c0 + 1 + per_tab[i] * 8);
         wait_cyc(c0 + per_tab[i] * 8 + 8);
         chk("q_empty_lvl", q.size(), 0);
      end

      // level change mid-run at drop_cnt=10: overshoot fires on next pix_en
      restart(c0);
      go(4'd0);
      wait_cyc(c0 + 41);
      level = 4'd9; level_load = 1'b1;
      @(negedge clk_in);
      level_load = 1'b0;
      q.push_back(c0 + 45);
      q.push_back(c0 + 61);
      wait_cyc(c0 + 70);
      chk("q_empty_lvlchg", q.size(), 0);

      // soft drop at drop_cnt=10, then release back to period 20
      restart(c0);
      go(4'd0);
      wait_cyc(c0 + 41);
      soft_drop = 1'b1;
      q.push_back(c0 + 45); q.push_back(c0 + 53);
      q.push_back(c0 + 61); q.push_back(c0 + 69);
      wait_cyc(c0 + 70);
      soft_drop = 1'b0;
      q.push_back(c0 + 149);
      wait_cyc(c0 + 160);
      chk("q_empty_soft", q.size(), 0);

      // pause at drop_cnt=7, resume 100 clocks later, pause+resume together
      restart(c0);
      go(4'd0);
      wait_cyc(c0 + 29);
      pause_req = 1'b1;
      @(negedge clk_in);
      pause_req = 1'b0;
      chk("pause_state", int'(state), 2);
      wait_cyc(c0 + 129);
      resume_req = 1'b1;
      @(negedge clk_in);
      resume_req = 1'b0;
      chk("resume_state", int'(state), 1);
      q.push_back(c0 + 181);
      wait_cyc(c0 + 180);
      pause_req = 1'b1; resume_req = 1'b1;
      @(negedge clk_in);
      pause_req = 1'b0; resume_req = 1'b0;
      chk("pause_resume_state", int'(state), 2);
      start = 1'b1;
      @(negedge clk_in);
      start = 1'b0;
      @(negedge clk_in);
      chk("start_ignored", int'(state), 2);
      wait_cyc(c0 + 260);
      chk("q_empty_pause", q.size(), 0);

      // one-cycle reset on the edge that would have produced a tick
      restart(c0);
      go(4'd0);
      wait_cyc(c0 + 80);
      rst_in = 1'b1;
      @(negedge clk_in);
      chk("midrst_drop_tick", int'(drop_tick), 0);
      chk("midrst_state", int'(state), 0);
      chk("midrst_pix_en", int'(pix_en), 0);
      rst_in = 1'b0;
      repeat (100) @(negedge clk_in);
      chk("midrst_idle", int'(state), 0);
      chk("q_empty_rst", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
